// File: rtl/display_pkg.sv
// Shared display constants for the score board: segment encodings,
// digit geometry and a one-cycle BCD adder used by the score register.
package display_pkg;

    localparam int         NUM_DIGITS = 8;
    localparam logic [2:0] DP_INDEX   = 3'd4;

    // Active-low segment patterns, bit 0 = a ... bit 6 = g.
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;

    // Adds 0..3 to a 4-digit BCD value; bit 16 is the decimal carry out.
    function automatic logic [16:0] bcd_add(input logic [15:0] a, input logic [1:0] inc);
        logic [4:0]  d;
        logic        c;
        logic [15:0] s;
        c = 1'b0;
        s = '0;
        for (int i = 0; i < 4; i++) begin
            d = 5'(a[4*i +: 4]) + 5'(c);
            if (i == 0) d = d + 5'(inc);
            if (d > 5'd9) begin
                s[4*i +: 4] = 4'(d - 5'd10);
                c = 1'b1;
            end else begin
                s[4*i +: 4] = d[3:0];
                c = 1'b0;
            end
        end
        return {c, s};
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD to active-low seven-segment decoder; nibbles 10-15 go blank.
module seg7_decoder
    import display_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/score_display.sv
// Score and high-score keeper fed by frame-domain coin hits, scanned out
// onto an 8-digit multiplexed seven-segment display.
module score_display
    import display_pkg::*;
#(
    parameter int          REFRESH_DIV = 100000,
    parameter logic [15:0] SAT_BCD     = 16'h9999
) (
    input  logic        CLK100MHZ,
    input  logic        CPU_RESETN,
    input  logic [2:0]  coin_hit,
    input  logic        clear,
    input  logic        game_over,
    output logic [15:0] score_bcd,
    output logic [15:0] high_bcd,
    output logic [7:0]  AN,
    output logic [6:0]  SEG,
    output logic        DP
);

    localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    // Bit order: {game_over, clear, coin_hit[2:0]}.
    logic [4:0] sync1, sync2, prev, rise;

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
        end else begin
            sync1 <= {game_over, clear, coin_hit};
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign rise = sync2 & ~prev;

    logic [1:0]  inc;
    logic        clear_now;
    logic [16:0] sum;
    logic [15:0] score_next;

    // clear acts on its synchronized level; a rise implies that level anyway.
    always_comb begin
        inc        = {1'b0, rise[0]} + {1'b0, rise[1]} + {1'b0, rise[2]};
        clear_now  = sync2[3] | rise[3];
        sum        = bcd_add(score_bcd, inc);
        score_next = sum[15:0];
        if (clear_now)
            score_next = 16'h0000;
        else if (sum[16] || (sum[15:0] > SAT_BCD))
            score_next = SAT_BCD;
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            score_bcd <= 16'h0000;
            high_bcd  <= 16'h0000;
        end else begin
            score_bcd <= score_next;
            if (rise[4] && (score_bcd > high_bcd))
                high_bcd <= score_bcd;
        end
    end

    logic [DIV_W-1:0] div_cnt;
    logic [2:0]       idx;

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            div_cnt <= '0;
            idx     <= 3'd0;
        end else if (div_cnt == DIV_W'(REFRESH_DIV - 1)) begin
            div_cnt <= '0;
            idx     <= idx + 3'd1;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    logic [3:0] digit;
    logic       blank;
    logic [6:0] seg_dec;

    // Indices 4-7 show the high score, 0-3 the score with leading zeros blanked.
    always_comb begin
        digit = idx[2] ? high_bcd[{idx[1:0], 2'b00} +: 4] : score_bcd[{idx[1:0], 2'b00} +: 4];
        blank = 1'b0;
        case (idx)
            3'd1: blank = (score_bcd[15:4] == 12'h000);
            3'd2: blank = (score_bcd[15:8] == 8'h00);
            3'd3: blank = (score_bcd[15:12] == 4'h0);
            default: blank = 1'b0;
        endcase
    end

    seg7_decoder u_dec (
        .bcd (digit),
        .seg (seg_dec)
    );

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            AN  <= 8'hFF;
            SEG <= SEG_BLANK;
            DP  <= 1'b1;
        end else begin
            AN  <= ~(8'b1 << idx);
            SEG <= blank ? SEG_BLANK : seg_dec;
            DP  <= (idx != DP_INDEX);
        end
    end

endmodule
